// File: rtl/lsu_exec_queue.sv
// Load/store execution queue: buffers issued memory ops, computes the EA,
// checks alignment, issues one load at a time and writes results to the ROB.
module lsu_exec_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int ROB_W       = 4,
    parameter int CHECK_ALIGN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_rob_id,
    output logic             wb_valid,
    output logic [ROB_W-1:0] wb_rob_id,
    output logic [XLEN-1:0]  wb_value,
    output logic [XLEN-1:0]  wb_addr,
    output logic             wb_misalign,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic [1:0]       mem_size,
    input  logic             mem_done,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             sb_full,
    input  logic             rollback
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       q_op   [DEPTH];
    logic [XLEN-1:0]  q_addr [DEPTH];
    logic [XLEN-1:0]  q_rs2  [DEPTH];
    logic [ROB_W-1:0] q_rob  [DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic [2:0]       ld_f3_q;
    logic [ROB_W-1:0] ld_rob_q;
    logic [XLEN-1:0]  ld_addr_q;

    logic [3:0]       hd_op;
    logic [XLEN-1:0]  hd_addr;
    logic [XLEN-1:0]  hd_rs2;
    logic [ROB_W-1:0] hd_rob;
    logic [1:0]       hd_sz;
    logic             hd_st;
    logic             hd_mis;

    logic enq, deq, can_disp;
    logic disp_mis, disp_st, disp_ld;
    logic ld_done;

    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] st_val;
    logic [1:0]      hd_msize;

    // Head decode, dispatch decision and next-state computation
    always_comb begin
        hd_op   = q_op[head_q];
        hd_addr = q_addr[head_q];
        hd_rs2  = q_rs2[head_q];
        hd_rob  = q_rob[head_q];
        hd_st   = hd_op[3];
        hd_sz   = hd_op[1:0];
        hd_mis  = (CHECK_ALIGN != 0) &&
                  (((hd_sz == 2'b01) && hd_addr[0]) ||
                   ((hd_sz == 2'b10) && (hd_addr[1:0] != 2'b00)));
        hd_msize = (hd_sz == 2'b11) ? 2'b10 : hd_sz;

        enq      = in_valid && in_ready && !rollback;
        can_disp = (state_q == S_IDLE) && (count_q != '0) && !rollback;
        disp_mis = can_disp && hd_mis;
        disp_st  = can_disp && !hd_mis && hd_st && !sb_full;
        disp_ld  = can_disp && !hd_mis && !hd_st;
        deq      = disp_mis || disp_st || disp_ld;

        if (rollback) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(enq) - CW'(deq);
        end

        ld_done = (state_q == S_WAIT) && mem_done && !rollback;

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (disp_ld) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done)      state_d = S_IDLE;
                else if (rollback) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (mem_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load data extension and store data masking
    always_comb begin
        ld_ext = mem_rdata;
        case (ld_f3_q)
            3'b000:  ld_ext = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
            default: ld_ext = mem_rdata;
        endcase

        st_val = hd_rs2;
        case (hd_sz)
            2'b00:   st_val = {{(XLEN-8){1'b0}}, hd_rs2[7:0]};
            2'b01:   st_val = {{(XLEN-16){1'b0}}, hd_rs2[15:0]};
            default: st_val = hd_rs2;
        endcase
    end

    // Queue storage; entries carry the precomputed effective address
    always_ff @(posedge clk) begin
        if (!rst && rdy && enq) begin
            q_op[tail_q]   <= in_op;
            q_addr[tail_q] <= in_rs1 + in_imm;
            q_rs2[tail_q]  <= in_rs2;
            q_rob[tail_q]  <= in_rob_id;
        end
    end

    // Control FSM, queue pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_ready    <= 1'b1;
            wb_valid    <= 1'b0;
            wb_rob_id   <= '0;
            wb_value    <= '0;
            wb_addr     <= '0;
            wb_misalign <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_size    <= '0;
            ld_f3_q     <= '0;
            ld_rob_q    <= '0;
            ld_addr_q   <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            count_q  <= count_d;
            in_ready <= (state_d != S_DRAIN) && (count_d < CW'(DEPTH));
            wb_valid <= 1'b0;
            mem_req  <= 1'b0;

            if (rollback) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                head_q <= head_q + PW'(deq);
                tail_q <= tail_q + PW'(enq);
            end

            if (disp_mis) begin
                wb_valid    <= 1'b1;
                wb_misalign <= 1'b1;
                wb_value    <= '0;
                wb_addr     <= hd_addr;
                wb_rob_id   <= hd_rob;
            end

            if (disp_st) begin
                wb_valid    <= 1'b1;
                wb_misalign <= 1'b0;
                wb_value    <= st_val;
                wb_addr     <= hd_addr;
                wb_rob_id   <= hd_rob;
            end

            if (disp_ld) begin
                mem_req   <= 1'b1;
                mem_addr  <= hd_addr;
                mem_size  <= hd_msize;
                ld_f3_q   <= hd_op[2:0];
                ld_rob_q  <= hd_rob;
                ld_addr_q <= hd_addr;
            end

            if (ld_done) begin
                wb_valid    <= 1'b1;
                wb_misalign <= 1'b0;
                wb_value    <= ld_ext;
                wb_addr     <= ld_addr_q;
                wb_rob_id   <= ld_rob_q;
            end
        end
    end

endmodule

// File: tb/tb_lsu_exec_queue.sv
// Directed bench for lsu_exec_queue; a second instance with alignment
// checking disabled covers the unchecked-address path.
module tb_lsu_exec_queue;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_valid, in_valid_b;
    logic [3:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic [3:0]  in_rob_id;
    logic        mem_done, sb_full, rollback;
    logic [31:0] mem_rdata;

    logic        in_ready, wb_valid, wb_misalign, mem_req;
    logic [3:0]  wb_rob_id;
    logic [31:0] wb_value, wb_addr, mem_addr;
    logic [1:0]  mem_size;

    logic        in_ready_b, wb_valid_b, wb_misalign_b, mem_req_b;
    logic [3:0]  wb_rob_id_b;
    logic [31:0] wb_value_b, wb_addr_b, mem_addr_b;
    logic [1:0]  mem_size_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_exec_queue #(.XLEN(32), .DEPTH(4), .ROB_W(4), .CHECK_ALIGN(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_rob_id(in_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_addr(wb_addr), .wb_misalign(wb_misalign),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .sb_full(sb_full), .rollback(rollback)
    );

    lsu_exec_queue #(.XLEN(32), .DEPTH(4), .ROB_W(4), .CHECK_ALIGN(0)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_rob_id(in_rob_id),
        .wb_valid(wb_valid_b), .wb_rob_id(wb_rob_id_b),
        .wb_value(wb_value_b), .wb_addr(wb_addr_b),
        .wb_misalign(wb_misalign_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_size(mem_size_b),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .sb_full(sb_full), .rollback(rollback)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] rs1,
                          input logic [31:0] imm, input logic [31:0] rs2,
                          input logic [3:0] rob);
        in_op     = op;
        in_rs1    = rs1;
        in_imm    = imm;
        in_rs2    = rs2;
        in_rob_id = rob;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [3:0] rob);
        set_op(op, rs1, imm, rs2, rob);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb_expect(input string tag, input logic [3:0] rob,
                             input logic [31:0] val, input logic [31:0] addr);
        check({tag, "_vld"}, 32'(wb_valid), 32'd1);
        check({tag, "_rob"}, 32'(wb_rob_id), 32'(rob));
        check({tag, "_val"}, wb_value, val);
        check({tag, "_addr"}, wb_addr, addr);
        check({tag, "_mis"}, 32'(wb_misalign), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        in_valid = 1'b0; in_valid_b = 1'b0;
        set_op(4'h0, 32'h0, 32'h0, 32'h0, 4'h0);
        mem_done = 1'b0; mem_rdata = 32'h0;
        sb_full = 1'b0; rollback = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_mis", 32'(wb_misalign), 32'd0);
        check("rst_val", wb_value, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);

        // LB sign-extended
        push(4'b0000, 32'h1000, 32'd3, 32'h0, 4'd1);
        check("lb_noreq_yet", 32'(mem_req), 32'd0);
        tick();
        check("lb_req", 32'(mem_req), 32'd1);
        check("lb_maddr", mem_addr, 32'h1003);
        check("lb_msize", 32'(mem_size), 32'd0);
        check("lb_nowb", 32'(wb_valid), 32'd0);
        mem_done = 1'b1; mem_rdata = 32'h0000_00F0;
        tick();
        mem_done = 1'b0;
        wb_expect("lb", 4'd1, 32'hFFFF_FFF0, 32'h1003);
        check("lb_req_off", 32'(mem_req), 32'd0);
        tick();
        check("lb_wb_off", 32'(wb_valid), 32'd0);

        // LBU zero-extended
        push(4'b0100, 32'h1000, 32'd3, 32'h0, 4'd2);
        tick();
        check("lbu_req", 32'(mem_req), 32'd1);
        mem_done = 1'b1; mem_rdata = 32'h0000_00F0;
        tick();
        mem_done = 1'b0;
        wb_expect("lbu", 4'd2, 32'h0000_00F0, 32'h1003);
        tick();

        // SH stalled by store buffer
        sb_full = 1'b1;
        push(4'b1001, 32'h2000, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sh_stall_wb", 32'(wb_valid), 32'd0);
            check("sh_stall_req", 32'(mem_req), 32'd0);
        end
        sb_full = 1'b0;
        tick();
        wb_expect("sh", 4'd3, 32'h0000_BEEF, 32'h0000_1FFE);
        check("sh_noreq", 32'(mem_req), 32'd0);
        tick();
        check("sh_wb_off", 32'(wb_valid), 32'd0);

        // Misaligned LW: faults when checked, issues when unchecked
        set_op(4'b0010, 32'h1000, 32'd2, 32'h0, 4'd4);
        in_valid = 1'b1; in_valid_b = 1'b1;
        tick();
        in_valid = 1'b0; in_valid_b = 1'b0;
        tick();
        check("mis_vld", 32'(wb_valid), 32'd1);
        check("mis_flag", 32'(wb_misalign), 32'd1);
        check("mis_val", wb_value, 32'h0);
        check("mis_rob", 32'(wb_rob_id), 32'd4);
        check("mis_noreq", 32'(mem_req), 32'd0);
        check("nochk_req", 32'(mem_req_b), 32'd1);
        check("nochk_maddr", mem_addr_b, 32'h1002);
        check("nochk_msize", 32'(mem_size_b), 32'd2);
        mem_done = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_done = 1'b0;
        check("nochk_wbv", 32'(wb_valid_b), 32'd1);
        check("nochk_val", wb_value_b, 32'h1234_5678);
        check("nochk_mis", 32'(wb_misalign_b), 32'd0);
        check("mis_wb_off", 32'(wb_valid), 32'd0);
        tick();

        // Fill queue behind a load waiting on memory
        push(4'b0010, 32'h3000, 32'd0, 32'h0, 4'd5);
        tick();
        check("fill_req", 32'(mem_req), 32'd1);
        in_valid = 1'b1;
        set_op(4'b0100, 32'h3000, 32'h10, 32'h0, 4'd6);
        tick();
        set_op(4'b1000, 32'h3000, 32'h20, 32'h1122_3344, 4'd7);
        tick();
        set_op(4'b0001, 32'h3000, 32'h30, 32'h0, 4'd8);
        tick();
        check("fill_rdy3", 32'(in_ready), 32'd1);
        set_op(4'b1010, 32'h3000, 32'h40, 32'hCAFE_F00D, 4'd9);
        tick();
        check("fill_rdy4", 32'(in_ready), 32'd0);
        set_op(4'b0010, 32'h3000, 32'h50, 32'h0, 4'd10);
        tick();
        check("full_hold", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        mem_done = 1'b1; mem_rdata = 32'h0000_ABCD;
        tick();
        mem_done = 1'b0;
        wb_expect("q0", 4'd5, 32'h0000_ABCD, 32'h3000);
        check("q0_rdy", 32'(in_ready), 32'd0);
        tick();
        check("q1_req", 32'(mem_req), 32'd1);
        check("q1_maddr", mem_addr, 32'h3010);
        check("q1_rdy", 32'(in_ready), 32'd1);
        mem_done = 1'b1; mem_rdata = 32'h0000_0080;
        tick();
        mem_done = 1'b0;
        wb_expect("q1", 4'd6, 32'h0000_0080, 32'h3010);
        tick();
        wb_expect("q2", 4'd7, 32'h0000_0044, 32'h3020);
        tick();
        check("q3_req", 32'(mem_req), 32'd1);
        check("q3_msize", 32'(mem_size), 32'd1);
        check("q3_nowb", 32'(wb_valid), 32'd0);
        mem_done = 1'b1; mem_rdata = 32'h0000_8001;
        tick();
        mem_done = 1'b0;
        wb_expect("q3", 4'd8, 32'hFFFF_8001, 32'h3030);
        tick();
        wb_expect("q4", 4'd9, 32'hCAFE_F00D, 32'h3040);
        tick();
        check("q_end_wb", 32'(wb_valid), 32'd0);
        check("q_end_req", 32'(mem_req), 32'd0);

        // Rollback while a load is outstanding -> drain
        push(4'b0010, 32'h4000, 32'd0, 32'h0, 4'd11);
        tick();
        check("rb_req", 32'(mem_req), 32'd1);
        rollback = 1'b1;
        in_valid = 1'b1;
        set_op(4'b1010, 32'h4100, 32'd0, 32'h5555_5555, 4'd12);
        tick();
        rollback = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_rdy", 32'(in_ready), 32'd0);
            check("drain_wb", 32'(wb_valid), 32'd0);
            if (i < 2) tick();
        end
        mem_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_done = 1'b0;
        check("drain_done_wb", 32'(wb_valid), 32'd0);
        check("drain_done_rdy", 32'(in_ready), 32'd1);
        tick();
        check("drain_empty_req", 32'(mem_req), 32'd0);
        check("drain_empty_wb", 32'(wb_valid), 32'd0);

        // Rollback coinciding with mem_done
        push(4'b0010, 32'h5000, 32'd0, 32'h0, 4'd12);
        tick();
        check("rbd_req", 32'(mem_req), 32'd1);
        rollback = 1'b1;
        mem_done = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        rollback = 1'b0;
        mem_done = 1'b0;
        check("rbd_wb", 32'(wb_valid), 32'd0);
        check("rbd_rdy", 32'(in_ready), 32'd1);
        tick();
        check("rbd_wb2", 32'(wb_valid), 32'd0);
        check("rbd_req2", 32'(mem_req), 32'd0);

        // rdy=0 freezes a pending writeback pulse
        push(4'b1010, 32'h6000, 32'd0, 32'h0102_0304, 4'd13);
        tick();
        check("frz_wb", 32'(wb_valid), 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("frz_hold", 32'(wb_valid), 32'd1);
            check("frz_rob", 32'(wb_rob_id), 32'd13);
            check("frz_val", wb_value, 32'h0102_0304);
        end
        rdy = 1'b1;
        tick();
        check("frz_release", 32'(wb_valid), 32'd0);

        // Reset during WAIT
        push(4'b0010, 32'h7000, 32'd0, 32'h0, 4'd14);
        tick();
        check("rw_req", 32'(mem_req), 32'd1);
        check("rw_maddr", mem_addr, 32'h7000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_req0", 32'(mem_req), 32'd0);
        check("rw_maddr0", mem_addr, 32'h0);
        check("rw_wbv0", 32'(wb_valid), 32'd0);
        check("rw_val0", wb_value, 32'h0);
        check("rw_addr0", wb_addr, 32'h0);
        check("rw_rob0", 32'(wb_rob_id), 32'd0);
        check("rw_rdy", 32'(in_ready), 32'd1);
        mem_done = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        mem_done = 1'b0;
        check("rw_idle_done", 32'(wb_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
